// File: rtl/rx_lane_deframer.sv
// Receive deframer for the 4-lane 6-bit luma link: hunts for the frame marker,
// tracks lines separated by hsync markers and emits 4-pixel beats with status.
module rx_lane_deframer #(
  parameter int          LINE_SYM = 160,
  parameter int          LINES    = 240,
  parameter logic [23:0] FRAME1   = 24'haab155,
  parameter logic [23:0] FRAME0   = 24'haa8d55,
  parameter logic [7:0]  HSYNC    = 8'h55
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        TransValid,
  input  logic [5:0]  Trans0Data,
  input  logic [5:0]  Trans1Data,
  input  logic [5:0]  Trans2Data,
  input  logic [5:0]  Trans3Data,
  output logic        m_axis_video_tvalid,
  output logic [19:0] m_axis_video_tdata,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic        FrameLocked,
  output logic        FrameId,
  output logic        FrameDone,
  output logic        SyncErr,
  output logic [11:0] RxLineCount
);

  localparam int SYM_W = (LINE_SYM > 1) ? $clog2(LINE_SYM) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(LINE_SYM - 1);
  localparam logic [11:0]      LINE_LAST = 12'(LINES - 1);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_HSYNC = 2'd2
  } state_t;

  state_t           r_state;
  logic [23:0]      r_ones_sr;
  logic [23:0]      r_zeros_sr;
  logic [SYM_W-1:0] r_sym_cnt;
  logic [11:0]      r_line_cnt;
  logic [2:0]       r_hs_cnt;
  logic             r_tvalid;
  logic [19:0]      r_tdata;
  logic             r_tuser;
  logic             r_tlast;
  logic             r_locked;
  logic             r_frame_id;
  logic             r_frame_done;
  logic             r_sync_err;

  logic        w_is_one;
  logic        w_is_zero;
  logic        w_is_bad;
  logic [23:0] w_ones_next;
  logic [23:0] w_zeros_next;
  logic        w_frame1_match;
  logic        w_frame0_match;
  logic        w_frame_match;
  logic        w_hsync_match;
  logic        w_sym_last;
  logic        w_line_last;
  logic [19:0] w_pixels;

  assign w_is_one  = (Trans0Data == 6'h3f) && (Trans1Data == 6'h3f) &&
                     (Trans2Data == 6'h3f) && (Trans3Data == 6'h3f);
  assign w_is_zero = (Trans0Data == 6'h00) && (Trans1Data == 6'h00) &&
                     (Trans2Data == 6'h00) && (Trans3Data == 6'h00);
  // Data symbols keep bit 5 clear on every lane; anything else breaks the line.
  assign w_is_bad  = Trans0Data[5] | Trans1Data[5] | Trans2Data[5] | Trans3Data[5];

  // Marker matching looks at the history including the symbol arriving now.
  assign w_ones_next  = {r_ones_sr[22:0], w_is_one};
  assign w_zeros_next = {r_zeros_sr[22:0], w_is_zero};

  assign w_frame1_match = (w_ones_next == FRAME1) && (w_zeros_next == ~FRAME1);
  assign w_frame0_match = (w_ones_next == FRAME0) && (w_zeros_next == ~FRAME0);
  assign w_frame_match  = w_frame1_match | w_frame0_match;
  assign w_hsync_match  = (w_ones_next[7:0] == HSYNC) && (w_zeros_next[7:0] == ~HSYNC);

  assign w_sym_last  = (r_sym_cnt == SYM_LAST);
  assign w_line_last = (r_line_cnt == LINE_LAST);
  assign w_pixels    = {Trans3Data[4:0], Trans2Data[4:0], Trans1Data[4:0], Trans0Data[4:0]};

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_HUNT;
      r_ones_sr    <= '0;
      r_zeros_sr   <= '0;
      r_sym_cnt    <= '0;
      r_line_cnt   <= '0;
      r_hs_cnt     <= '0;
      r_tvalid     <= 1'b0;
      r_tdata      <= '0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_id   <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_tvalid     <= 1'b0;
      r_tuser      <= 1'b0;
      r_tlast      <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (TransValid) begin
        r_ones_sr  <= w_ones_next;
        r_zeros_sr <= w_zeros_next;
        if (w_frame_match) begin
          // A new marker always restarts the frame; inside a frame it means truncation.
          r_frame_id <= w_frame1_match;
          r_sym_cnt  <= '0;
          r_line_cnt <= '0;
          r_hs_cnt   <= '0;
          r_state    <= ST_DATA;
          r_locked   <= 1'b1;
          if (r_state != ST_HUNT) begin
            r_sync_err <= 1'b1;
          end
        end else begin
          case (r_state)
            ST_HUNT: begin
              r_locked <= 1'b0;
            end
            ST_DATA: begin
              if (w_is_bad) begin
                r_sync_err <= 1'b1;
                r_state    <= ST_HUNT;
                r_locked   <= 1'b0;
              end else begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_pixels;
                r_tuser  <= (r_line_cnt == 12'd0) && (r_sym_cnt == '0);
                r_tlast  <= w_sym_last;
                if (w_sym_last) begin
                  if (w_line_last) begin
                    r_frame_done <= 1'b1;
                    r_state      <= ST_HUNT;
                    r_locked     <= 1'b0;
                  end else begin
                    r_hs_cnt <= '0;
                    r_state  <= ST_HSYNC;
                  end
                end else begin
                  r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                end
              end
            end
            ST_HSYNC: begin
              if (r_hs_cnt == 3'd7) begin
                if (w_hsync_match) begin
                  r_line_cnt <= r_line_cnt + 12'd1;
                  r_sym_cnt  <= '0;
                  r_state    <= ST_DATA;
                end else begin
                  r_sync_err <= 1'b1;
                  r_state    <= ST_HUNT;
                  r_locked   <= 1'b0;
                end
              end else begin
                r_hs_cnt <= r_hs_cnt + 3'd1;
              end
            end
            default: begin
              r_state  <= ST_HUNT;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign m_axis_video_tvalid = r_tvalid;
  assign m_axis_video_tdata  = r_tdata;
  assign m_axis_video_tuser  = r_tuser;
  assign m_axis_video_tlast  = r_tlast;
  assign FrameLocked         = r_locked;
  assign FrameId             = r_frame_id;
  assign FrameDone           = r_frame_done;
  assign SyncErr             = r_sync_err;
  assign RxLineCount         = r_line_cnt;

endmodule

// File: tb/tb_rx_lane_deframer.sv
// Directed bench for rx_lane_deframer with a small line geometry (4 symbols x 3 lines).
module tb_rx_lane_deframer;

  localparam logic [23:0] FRAME1 = 24'haab155;
  localparam logic [23:0] FRAME0 = 24'haa8d55;

  logic        Cclk;
  logic        rstn;
  logic        TransValid;
  logic [5:0]  Trans0Data, Trans1Data, Trans2Data, Trans3Data;
  logic        m_axis_video_tvalid;
  logic [19:0] m_axis_video_tdata;
  logic        m_axis_video_tuser;
  logic        m_axis_video_tlast;
  logic        FrameLocked;
  logic        FrameId;
  logic        FrameDone;
  logic        SyncErr;
  logic [11:0] RxLineCount;

  int n_checks;
  int n_errors;
  int gap_max;

  logic [19:0] b_data [256];
  logic        b_user [256];
  logic        b_last [256];
  int          n_beats;
  int          n_sync;
  int          n_done;

  rx_lane_deframer #(
    .LINE_SYM (4),
    .LINES    (3)
  ) dut (
    .Cclk                (Cclk),
    .rstn                (rstn),
    .TransValid          (TransValid),
    .Trans0Data          (Trans0Data),
    .Trans1Data          (Trans1Data),
    .Trans2Data          (Trans2Data),
    .Trans3Data          (Trans3Data),
    .m_axis_video_tvalid (m_axis_video_tvalid),
    .m_axis_video_tdata  (m_axis_video_tdata),
    .m_axis_video_tuser  (m_axis_video_tuser),
    .m_axis_video_tlast  (m_axis_video_tlast),
    .FrameLocked         (FrameLocked),
    .FrameId             (FrameId),
    .FrameDone           (FrameDone),
    .SyncErr             (SyncErr),
    .RxLineCount         (RxLineCount)
  );

  initial Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  // Beat/pulse recorder, sampled just after each active edge.
  initial begin
    n_beats = 0;
    n_sync  = 0;
    n_done  = 0;
  end
  always @(posedge Cclk) begin
    #1;
    if (m_axis_video_tvalid) begin
      if (n_beats < 256) begin
        b_data[n_beats] = m_axis_video_tdata;
        b_user[n_beats] = m_axis_video_tuser;
        b_last[n_beats] = m_axis_video_tlast;
      end
      n_beats++;
    end
    if (SyncErr) n_sync++;
    if (FrameDone) n_done++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pack(input logic [5:0] l0, input logic [5:0] l1,
                                       input logic [5:0] l2, input logic [5:0] l3);
    return {l3[4:0], l2[4:0], l1[4:0], l0[4:0]};
  endfunction

  // Called at a falling edge; returns at the falling edge after the symbol was taken.
  task automatic send(input logic [5:0] l0, input logic [5:0] l1,
                      input logic [5:0] l2, input logic [5:0] l3);
    int gap;
    Trans0Data = l0;
    Trans1Data = l1;
    Trans2Data = l2;
    Trans3Data = l3;
    TransValid = 1'b1;
    @(negedge Cclk);
    TransValid = 1'b0;
    gap = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
    repeat (gap) @(negedge Cclk);
  endtask

  task automatic send_bits(input logic [23:0] m, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (m[i]) send(6'h3f, 6'h3f, 6'h3f, 6'h3f);
      else      send(6'h00, 6'h00, 6'h00, 6'h00);
    end
  endtask

  task automatic send_val(input int v);
    send(6'(v), 6'(v + 1), 6'(v + 2), 6'(v + 3));
  endtask

  // Two lines of a frame interrupted by a FRAME1 marker midway through line 1.
  task automatic run_mid(input int b0);
    int s0;
    send_bits(FRAME1, 24);
    for (int s = 0; s < 4; s++) send_val(s + 5);
    send_bits(24'h55, 8);
    for (int s = 4; s < 6; s++) send_val(s + 5);
    check_val("mid_line1", 32'(RxLineCount), 32'd1);
    s0 = n_sync;
    send_bits(FRAME1, 24);
    check_val("mid_syncerr", 32'(n_sync - s0), 32'd1);
    check_val("mid_line0", 32'(RxLineCount), 32'd0);
    check_val("mid_locked", 32'(FrameLocked), 32'd1);
    send_val(20);
    check_val("mid_beats", 32'(n_beats - b0), 32'd7);
    for (int k = 0; k < 7; k++) begin
      check_val("mid_tuser", 32'(b_user[b0 + k]), 32'((k == 0) || (k == 6)));
      check_val("mid_tlast", 32'(b_last[b0 + k]), 32'(k == 3));
      check_val("mid_tdata", 32'(b_data[b0 + k]),
                32'(pack(6'((k == 6) ? 20 : k + 5), 6'((k == 6) ? 21 : k + 6),
                         6'((k == 6) ? 22 : k + 7), 6'((k == 6) ? 23 : k + 8))));
    end
  endtask

  initial begin
    int b0;
    int s0;
    int d0;
    int r1;
    logic [5:0] rv [4];

    n_checks   = 0;
    n_errors   = 0;
    gap_max    = 0;
    rstn       = 1'b0;
    TransValid = 1'b0;
    Trans0Data = '0;
    Trans1Data = '0;
    Trans2Data = '0;
    Trans3Data = '0;
    repeat (3) @(negedge Cclk);
    rstn = 1'b1;
    @(negedge Cclk);

    check_val("rst_tvalid", 32'(m_axis_video_tvalid), 32'd0);
    check_val("rst_tdata",  32'(m_axis_video_tdata),  32'd0);
    check_val("rst_locked", 32'(FrameLocked), 32'd0);
    check_val("rst_syncerr", 32'(SyncErr), 32'd0);
    check_val("rst_line",   32'(RxLineCount), 32'd0);

    // Random data with no marker: nothing happens.
    b0 = n_beats;
    s0 = n_sync;
    for (int i = 0; i < 100; i++) begin
      for (int l = 0; l < 4; l++) rv[l] = 6'($urandom_range(0, 31));
      send(rv[0], rv[1], rv[2], rv[3]);
    end
    check_val("hunt_beats",  32'(n_beats - b0), 32'd0);
    check_val("hunt_sync",   32'(n_sync - s0), 32'd0);
    check_val("hunt_locked", 32'(FrameLocked), 32'd0);

    // Full FRAME1 frame: 3 lines of 4 symbols.
    b0 = n_beats;
    d0 = n_done;
    send_bits(FRAME1, 24);
    check_val("f1_locked", 32'(FrameLocked), 32'd1);
    check_val("f1_id",     32'(FrameId), 32'd1);
    check_val("f1_nobeat", 32'(n_beats - b0), 32'd0);
    for (int ln = 0; ln < 3; ln++) begin
      if (ln != 0) send_bits(24'h55, 8);
      for (int s = 0; s < 4; s++) send_val(ln * 4 + s + 1);
    end
    check_val("f1_tlast12", 32'(m_axis_video_tlast), 32'd1);
    check_val("f1_done",    32'(FrameDone), 32'd1);
    check_val("f1_unlock",  32'(FrameLocked), 32'd0);
    check_val("f1_line",    32'(RxLineCount), 32'd2);
    @(negedge Cclk);
    check_val("f1_done_pulse", 32'(FrameDone), 32'd0);
    check_val("f1_done_cnt",   32'(n_done - d0), 32'd1);
    check_val("f1_beats",      32'(n_beats - b0), 32'd12);
    for (int k = 0; k < 12; k++) begin
      check_val("f1_tuser", 32'(b_user[b0 + k]), 32'(k == 0));
      check_val("f1_tlast", 32'(b_last[b0 + k]), 32'((k % 4) == 3));
      check_val("f1_tdata", 32'(b_data[b0 + k]),
                32'(pack(6'(k + 1), 6'(k + 2), 6'(k + 3), 6'(k + 4))));
    end

    // FRAME0 frame with known lane data, then a corrupted hsync.
    send_bits(FRAME0, 24);
    check_val("f0_id", 32'(FrameId), 32'd0);
    send(6'h01, 6'h02, 6'h03, 6'h04);
    check_val("f0_tvalid", 32'(m_axis_video_tvalid), 32'd1);
    check_val("f0_tdata",  32'(m_axis_video_tdata), 32'h20c41);
    check_val("f0_tuser",  32'(m_axis_video_tuser), 32'd1);
    for (int s = 1; s < 4; s++) send(6'h01, 6'h02, 6'h03, 6'h04);
    s0 = n_sync;
    send_bits(24'h28, 7);
    check_val("hs_nosync_yet", 32'(n_sync - s0), 32'd0);
    check_val("hs_locked",     32'(FrameLocked), 32'd1);
    send_bits(24'h1, 1);
    check_val("hs_syncerr", 32'(SyncErr), 32'd1);
    check_val("hs_unlock",  32'(FrameLocked), 32'd0);
    b0 = n_beats;
    for (int s = 0; s < 4; s++) send_val(s);
    check_val("hs_nobeats", 32'(n_beats - b0), 32'd0);
    check_val("hs_onesync", 32'(n_sync - s0), 32'd1);

    // Bad data symbol mid-line.
    send_bits(FRAME1, 24);
    b0 = n_beats;
    send_val(1);
    send_val(2);
    send(6'h01, 6'h02, 6'h21, 6'h04);
    check_val("bad_syncerr", 32'(SyncErr), 32'd1);
    check_val("bad_tvalid",  32'(m_axis_video_tvalid), 32'd0);
    check_val("bad_unlock",  32'(FrameLocked), 32'd0);
    for (int s = 0; s < 3; s++) send_val(s);
    check_val("bad_beats", 32'(n_beats - b0), 32'd2);

    // Marker mid-line, back-to-back symbols.
    r1 = n_beats;
    run_mid(r1);

    // Asynchronous reset while inside a frame.
    check_val("pre_rst_locked", 32'(FrameLocked), 32'd1);
    rstn = 1'b0;
    #1;
    check_val("arst_locked", 32'(FrameLocked), 32'd0);
    check_val("arst_tdata",  32'(m_axis_video_tdata), 32'd0);
    check_val("arst_id",     32'(FrameId), 32'd0);
    @(negedge Cclk);
    rstn = 1'b1;
    @(negedge Cclk);

    // Same sequence with random spacing of 1..25 cycles.
    gap_max = 24;
    b0 = n_beats;
    run_mid(b0);
    gap_max = 0;
    for (int k = 0; k < 7; k++) begin
      check_val("gap_same_data", 32'(b_data[b0 + k]), 32'(b_data[r1 + k]));
      check_val("gap_same_user", 32'(b_user[b0 + k]), 32'(b_user[r1 + k]));
      check_val("gap_same_last", 32'(b_last[b0 + k]), 32'(b_last[r1 + k]));
    end

    repeat (2) @(negedge Cclk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
